// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update signals exchanged between the pipeline and
// the branch predictor.
interface branch_predictor_if;
  logic [31:0] f_pc;
  logic [31:0] pc_predicted;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_jump_code;
  logic [31:0] upd_nextpc;
  logic        upd_fail;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_miss;

  modport master (
    output f_pc, upd_valid, upd_pc, upd_jump_code, upd_nextpc, upd_fail,
    input  pc_predicted, pred_hit, redirect, redirect_pc, cnt_branch, cnt_miss
  );

  modport slave (
    input  f_pc, upd_valid, upd_pc, upd_jump_code, upd_nextpc, upd_fail,
    output pc_predicted, pred_hit, redirect, redirect_pc, cnt_branch, cnt_miss
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational fetch lookup and execute-stage training.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic                clk,
  input logic                rst,
  branch_predictor_if.slave  bp
);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid  [ENTRIES];
  logic [TAG_W-1:0] tag    [ENTRIES];
  logic [31:0]      target [ENTRIES];
  logic [1:0]       ctr    [ENTRIES];

  logic [31:0] cnt_branch;
  logic [31:0] cnt_miss;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_en;
  logic             u_jump;
  logic             u_taken;
  logic             redirect;

  assign f_idx = bp.f_pc[IDX_W+1:2];
  assign f_tag = bp.f_pc[31:IDX_W+2];
  assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);

  assign bp.pred_hit     = f_hit;
  assign bp.pc_predicted = (f_hit && ctr[f_idx][1]) ? target[f_idx] : bp.f_pc + 32'd4;

  assign u_idx   = bp.upd_pc[IDX_W+1:2];
  assign u_tag   = bp.upd_pc[31:IDX_W+2];
  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign u_en    = bp.upd_valid && (bp.upd_jump_code != 2'b00);
  assign u_jump  = bp.upd_jump_code[1];
  // Conditional branches count as taken only when they leave the fall-through path.
  assign u_taken = u_jump || (bp.upd_nextpc != bp.upd_pc + 32'd4);

  assign redirect       = bp.upd_valid && bp.upd_fail;
  assign bp.redirect    = redirect;
  assign bp.redirect_pc = bp.upd_nextpc;
  assign bp.cnt_branch  = cnt_branch;
  assign bp.cnt_miss    = cnt_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (u_en) begin
      if (u_hit) begin
        if (u_jump) begin
          ctr[u_idx]    <= 2'b11;
          target[u_idx] <= bp.upd_nextpc;
        end else if (u_taken) begin
          if (ctr[u_idx] != 2'b11) ctr[u_idx] <= ctr[u_idx] + 2'd1;
          target[u_idx] <= bp.upd_nextpc;
        end else begin
          if (ctr[u_idx] != 2'b00) ctr[u_idx] <= ctr[u_idx] - 2'd1;
        end
      end else if (u_taken) begin
        // Allocation evicts whatever aliased entry lived at this index.
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= bp.upd_nextpc;
        ctr[u_idx]    <= u_jump ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branch <= '0;
      cnt_miss   <= '0;
    end else begin
      if (u_en && (cnt_branch != 32'hFFFF_FFFF)) cnt_branch <= cnt_branch + 32'd1;
      if (redirect && (cnt_miss != 32'hFFFF_FFFF)) cnt_miss <= cnt_miss + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table-level
// behavioural model of the predictor.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic clk;
  logic rst;
  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compareCount = 0;
  int failCount    = 0;

  // Model state: per-slot occupant PC, target and strength 0..3.
  bit          mValid  [ENTRIES];
  int unsigned mOwner  [ENTRIES];
  int unsigned mTarget [ENTRIES];
  int          mStrength [ENTRIES];
  longint      mBranch;
  longint      mMiss;

  function automatic int slotOf(int unsigned pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tagOf(int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit modelHit(int unsigned pc);
    int s = slotOf(pc);
    return mValid[s] && (tagOf(mOwner[s]) == tagOf(pc));
  endfunction

  function automatic int unsigned modelPredict(int unsigned pc);
    int s = slotOf(pc);
    if (modelHit(pc) && mStrength[s] >= 2) return mTarget[s];
    return pc + 4;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0; mOwner[i] = 0; mTarget[i] = 0; mStrength[i] = 1;
    end
    mBranch = 0;
    mMiss   = 0;
  endtask

  task automatic modelUpdate(bit uv, int unsigned upc, int jc, int unsigned unext, bit ufail);
    int s;
    bit taken;
    if (uv && jc != 0) begin
      s = slotOf(upc);
      taken = (jc >= 2) || (unext != upc + 4);
      if (mBranch < 64'hFFFF_FFFF) mBranch++;
      if (modelHit(upc)) begin
        if (jc >= 2) begin
          mStrength[s] = 3; mTarget[s] = unext;
        end else if (taken) begin
          mStrength[s] = (mStrength[s] + 1 > 3) ? 3 : mStrength[s] + 1;
          mTarget[s] = unext;
        end else begin
          mStrength[s] = (mStrength[s] - 1 < 0) ? 0 : mStrength[s] - 1;
        end
      end else if (taken) begin
        mValid[s] = 1; mOwner[s] = upc; mTarget[s] = unext;
        mStrength[s] = (jc >= 2) ? 3 : 2;
      end
    end
    if (uv && ufail && mMiss < 64'hFFFF_FFFF) mMiss++;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(int unsigned fpc, bit uv, int unsigned upc, int jc,
                               int unsigned unext, bit ufail);
    bp.f_pc          = fpc;
    bp.upd_valid     = uv;
    bp.upd_pc        = upc;
    bp.upd_jump_code = jc[1:0];
    bp.upd_nextpc    = unext;
    bp.upd_fail      = ufail;
  endtask

  task automatic checkAll(string tag);
    bit expRedirect = bp.upd_valid && bp.upd_fail;
    checkOutput({tag, ".pred_hit"},     {31'd0, bp.pred_hit},  {31'd0, modelHit(bp.f_pc)});
    checkOutput({tag, ".pc_predicted"}, bp.pc_predicted,       modelPredict(bp.f_pc));
    checkOutput({tag, ".redirect"},     {31'd0, bp.redirect},  {31'd0, expRedirect});
    checkOutput({tag, ".redirect_pc"},  bp.redirect_pc,        bp.upd_nextpc);
    checkOutput({tag, ".cnt_branch"},   bp.cnt_branch,         mBranch[31:0]);
    checkOutput({tag, ".cnt_miss"},     bp.cnt_miss,           mMiss[31:0]);
  endtask

  // One cycle: drive at negedge, check before posedge, train the model after it.
  task automatic stepCycle(string tag, int unsigned fpc, bit uv, int unsigned upc, int jc,
                           int unsigned unext, bit ufail);
    applyStimulus(fpc, uv, upc, jc, unext, ufail);
    #1;
    checkAll(tag);
    @(posedge clk);
    modelUpdate(uv, upc, jc, unext, ufail);
    @(negedge clk);
  endtask

  function automatic int unsigned randPc();
    return 32'h0000_1000 + ($urandom_range(0, 7) * 4) + ($urandom_range(0, 2) * (4 * ENTRIES));
  endfunction

  initial begin
    int unsigned fpc, upc, unext;
    int jc;
    bit uv, ufail;

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fresh table: plain fall-through prediction.
    applyStimulus(32'h100, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset.pred_hit", {31'd0, bp.pred_hit}, 32'd0);
    checkOutput("reset.pc_predicted", bp.pc_predicted, 32'h104);
    checkOutput("reset.redirect", {31'd0, bp.redirect}, 32'd0);
    @(negedge clk);

    // Mispredicted taken branch allocates; lookup in the same cycle sees the old table.
    applyStimulus(32'h100, 1, 32'h100, 1, 32'h180, 1);
    #1;
    checkOutput("alloc.redirect", {31'd0, bp.redirect}, 32'd1);
    checkOutput("alloc.redirect_pc", bp.redirect_pc, 32'h180);
    checkOutput("alloc.same_cycle_hit", {31'd0, bp.pred_hit}, 32'd0);
    @(posedge clk);
    modelUpdate(1, 32'h100, 1, 32'h180, 1);
    @(negedge clk);
    applyStimulus(32'h100, 0, 0, 0, 0, 0);
    #1;
    checkOutput("alloc.next_hit", {31'd0, bp.pred_hit}, 32'd1);
    checkOutput("alloc.next_pred", bp.pc_predicted, 32'h180);
    checkOutput("alloc.cnt_branch", bp.cnt_branch, 32'd1);
    checkOutput("alloc.cnt_miss", bp.cnt_miss, 32'd1);
    @(negedge clk);

    // Two not-taken resolutions weaken the counter below the taken threshold.
    stepCycle("nt1", 32'h100, 1, 32'h100, 1, 32'h104, 1);
    stepCycle("nt2", 32'h100, 1, 32'h100, 1, 32'h104, 0);
    applyStimulus(32'h100, 0, 0, 0, 0, 0);
    #1;
    checkOutput("weak.pred_hit", {31'd0, bp.pred_hit}, 32'd1);
    checkOutput("weak.pred", bp.pc_predicted, 32'h104);
    @(negedge clk);

    // Alias: JAL at 0x140 shares the slot of 0x100 and evicts it.
    stepCycle("alias.a", 32'h100, 1, 32'h100, 1, 32'h200, 0);
    stepCycle("alias.b", 32'h140, 1, 32'h140, 2, 32'h300, 1);
    applyStimulus(32'h100, 0, 0, 0, 0, 0);
    #1;
    checkOutput("alias.old_miss", {31'd0, bp.pred_hit}, 32'd0);
    bp.f_pc = 32'h140;
    #1;
    checkOutput("alias.new_hit", {31'd0, bp.pred_hit}, 32'd1);
    checkOutput("alias.new_pred", bp.pc_predicted, 32'h300);
    @(negedge clk);

    // Ignored update fields, address wrap on fall-through.
    stepCycle("ignored", 32'h140, 0, 32'h140, 1, 32'h104, 1);
    stepCycle("after_ignored", 32'h140, 0, 32'h0, 0, 32'h0, 0);
    stepCycle("wrap", 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0);

    // Reset mid-update discards it and clears everything at once.
    applyStimulus(32'h140, 1, 32'h180, 3, 32'h500, 1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst.pred_hit", {31'd0, bp.pred_hit}, 32'd0);
    checkOutput("rst.pred", bp.pc_predicted, 32'h144);
    checkOutput("rst.cnt_branch", bp.cnt_branch, 32'd0);
    checkOutput("rst.cnt_miss", bp.cnt_miss, 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stepCycle("post_rst.a", 32'h180, 0, 32'h0, 0, 32'h0, 0);
    stepCycle("post_rst.b", 32'h140, 0, 32'h0, 0, 32'h0, 0);

    // Randomized traffic over a few slots with aliasing tags.
    for (int n = 0; n < 400; n++) begin
      fpc   = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : randPc();
      upc   = randPc();
      jc    = $urandom_range(0, 3);
      uv    = ($urandom_range(0, 4) != 0);
      ufail = $urandom_range(0, 1);
      unext = ($urandom_range(0, 1) == 0) ? upc + 4 : ($urandom & 32'hFFFF_FFFC);
      stepCycle("rand", fpc, uv, upc, jc, unext, ufail);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, the number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 SHALL have parameter IDX_W, default 4, equal to log2(ENTRIES).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 f_pc  in  32  F-stage fetch address.
REQ-006 pc_predicted  out  32  predicted next fetch address for f_pc.
REQ-007 pred_hit  out  1  f_pc hit a valid entry.
REQ-008 upd_valid  in  1  E stage holds a valid instruction this cycle.
REQ-009 upd_pc  in  32  PC of the E-stage instruction.
REQ-010 upd_jump_code  in  2  E-stage jump_code: 00 none, 01 conditional branch, 10 JAL, 11 JALR.
REQ-011 upd_nextpc  in  32  resolved next PC from E-stage calculation.
REQ-012 upd_fail  in  1  E-stage misprediction indication.
REQ-013 redirect  out  1  flush F/D and refetch from redirect_pc.
REQ-014 redirect_pc  out  32  refetch address.
REQ-015 cnt_branch  out  32  resolved control-transfer count.
REQ-016 cnt_miss  out  32  misprediction count.

Function
REQ-017 Index SHALL be pc[IDX_W+1:2] and tag pc[31:IDX_W+2]; each entry holds valid (1), tag, target (32) and a 2-bit saturating counter.
REQ-018 Lookup SHALL be combinational: pred_hit = valid[idx] and tag match on f_pc.
REQ-019 pc_predicted SHALL be the entry target when pred_hit and counter[1]=1, else f_pc+4 (mod 2^32).
REQ-020 Update SHALL occur only when upd_valid=1 and upd_jump_code!=00; taken = (upd_nextpc != upd_pc+4) for 01, always 1 for 10/11.
REQ-021 On update hit with taken: counter SHALL increment saturating at 11, target SHALL be written with upd_nextpc.
REQ-022 On update hit with not taken: counter SHALL decrement saturating at 00; target unchanged.
REQ-023 On update miss with taken: entry SHALL be allocated (overwriting any occupant): valid=1, new tag, target=upd_nextpc, counter=10, or 11 for jump_code 10/11.
REQ-024 On update miss with not taken: no entry SHALL change.
REQ-025 For jump_code 10/11 on hit, counter SHALL be forced to 11.
REQ-026 redirect SHALL equal upd_valid & upd_fail combinationally; redirect_pc SHALL equal upd_nextpc.
REQ-027 Table update SHALL occur on the edge ending the update cycle; lookup in the same cycle to the same index SHALL return pre-update contents.
REQ-028 cnt_branch SHALL increment by 1 per qualifying update (REQ-020); cnt_miss by 1 per cycle with redirect=1; both SHALL saturate at 0xFFFFFFFF.
REQ-029 Update fields SHALL be ignored when upd_valid=0, including upd_fail.

Reset
REQ-030 While rst=1: all valid bits, targets and tags SHALL be 0, counters SHALL be 01, cnt_branch=cnt_miss=0.
REQ-031 Reset assertion mid-update SHALL discard the update; after release, lookups SHALL miss and pc_predicted SHALL be f_pc+4.

Verification
REQ-032 After reset, f_pc=0x100 -> pred_hit=0, pc_predicted=0x104, redirect=0.
REQ-033 Update upd_pc=0x100, jump_code=01, upd_nextpc=0x180, upd_fail=1 -> redirect=1, redirect_pc=0x180 that cycle; next cycle f_pc=0x100 -> pred_hit=1, pc_predicted=0x180; cnt_branch=1, cnt_miss=1.
REQ-034 Two further not-taken updates (upd_nextpc=0x104) of 0x100 -> counter 10->01->00; f_pc=0x100 then gives pc_predicted=0x104 with pred_hit=1.
REQ-035 Alias: allocate 0x100 taken, then taken JAL at 0x140 (same index, ENTRIES=16) -> f_pc=0x100 misses, f_pc=0x140 hits with counter 11.
REQ-036 Lookup and update of same index in one cycle -> lookup shows old value; new value visible next cycle.
REQ-037 upd_valid=0 with upd_fail=1 -> redirect=0, no table or counter change; rst pulsed mid-sequence -> all state returns to REQ-030 values immediately.
